// File: rtl/inst_ram_arbiter.sv
// rtl/inst_ram_arbiter.sv - arbitrates instruction RAM between fetch reads, loader writes and program switches
// Optional feature: define INST_ARB_TIMEOUT_EN to bound RD/WR waits to TO_CYC cycles with a sticky err flag.
module inst_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int PT_W   = 2,
  parameter int TO_CYC = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [31:0]       f_data,
  output logic              f_valid,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [31:0]       w_data,
  output logic              w_ack,
  input  logic [PT_W-1:0]   prog_sel,
  output logic [PT_W-1:0]   prog_type,
  output logic              prog_switched,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_rfin,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  input  logic              ram_wfin,
  output logic              err
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, SW = 2'd3} state_t;

  state_t            state_q, state_d;
  logic              last_w_q, last_w_d;
  logic              sw_cnt_q, sw_cnt_d;
  logic [PT_W-1:0]   prog_type_q, prog_type_d;
  logic [31:0]       f_data_q, f_data_d;
  logic              f_valid_q, f_valid_d;
  logic              w_ack_q, w_ack_d;
  logic              prog_sw_q, prog_sw_d;
  logic              ram_re_q, ram_re_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_raddr_q, ram_raddr_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic idle_ok, go_sw, pick_w, go_wr, go_rd;
  logic rd_busy, wr_busy, to_hit, rd_to, wr_to;

  // A lingering fin from the previous transaction must drain before anything new starts.
  assign idle_ok = (state_q == IDLE) && !ram_rfin && !ram_wfin;
  assign go_sw   = idle_ok && (prog_sel != prog_type_q);
  assign pick_w  = w_req && (!f_req || !last_w_q);
  assign go_wr   = idle_ok && !go_sw && pick_w;
  assign go_rd   = idle_ok && !go_sw && f_req && !pick_w;
  assign rd_busy = (state_q == RD) && !ram_rfin;
  assign wr_busy = (state_q == WR) && !ram_wfin;
  assign rd_to   = rd_busy && to_hit;
  assign wr_to   = wr_busy && to_hit;

`ifdef INST_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  assign to_hit = (to_cnt_q == TO_W'(TO_CYC - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    if (go_rd || go_wr) begin
      to_cnt_d = '0;
    end else if (rd_busy || wr_busy) begin
      if (to_hit) err_d = 1'b1;
      else        to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = TO_CYC[0];
  assign to_hit        = 1'b0;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go_sw)      state_d = SW;
        else if (go_wr) state_d = WR;
        else if (go_rd) state_d = RD;
      end
      RD:      if (ram_rfin || rd_to) state_d = IDLE;
      WR:      if (ram_wfin || wr_to) state_d = IDLE;
      SW:      if (sw_cnt_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_w_d    = last_w_q;
    sw_cnt_d    = sw_cnt_q;
    prog_type_d = prog_type_q;
    f_data_d    = f_data_q;
    f_valid_d   = 1'b0;
    w_ack_d     = 1'b0;
    prog_sw_d   = 1'b0;
    ram_re_d    = ram_re_q;
    ram_we_d    = ram_we_q;
    ram_raddr_d = ram_raddr_q;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (go_sw) begin
          prog_type_d = prog_sel;
          sw_cnt_d    = 1'b0;
        end else if (go_wr) begin
          ram_we_d    = 1'b1;
          ram_waddr_d = w_addr;
          ram_wdata_d = w_data;
          last_w_d    = 1'b1;
        end else if (go_rd) begin
          ram_re_d    = 1'b1;
          ram_raddr_d = f_addr;
          last_w_d    = 1'b0;
        end
      end
      RD: begin
        if (ram_rfin) begin
          f_data_d  = ram_rdata;
          f_valid_d = 1'b1;
          ram_re_d  = 1'b0;
        end else if (rd_to) begin
          f_data_d  = '0;
          f_valid_d = 1'b1;
          ram_re_d  = 1'b0;
        end
      end
      WR: begin
        if (ram_wfin || wr_to) begin
          ram_we_d = 1'b0;
          w_ack_d  = 1'b1;
        end
      end
      SW: begin
        if (sw_cnt_q) prog_sw_d = 1'b1;
        else          sw_cnt_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      last_w_q    <= 1'b0;
      sw_cnt_q    <= 1'b0;
      prog_type_q <= '0;
      f_data_q    <= '0;
      f_valid_q   <= 1'b0;
      w_ack_q     <= 1'b0;
      prog_sw_q   <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_raddr_q <= '0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      last_w_q    <= last_w_d;
      sw_cnt_q    <= sw_cnt_d;
      prog_type_q <= prog_type_d;
      f_data_q    <= f_data_d;
      f_valid_q   <= f_valid_d;
      w_ack_q     <= w_ack_d;
      prog_sw_q   <= prog_sw_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      ram_raddr_q <= ram_raddr_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign f_data        = f_data_q;
  assign f_valid       = f_valid_q;
  assign w_ack         = w_ack_q;
  assign prog_type     = prog_type_q;
  assign prog_switched = prog_sw_q;
  assign ram_re        = ram_re_q;
  assign ram_raddr     = ram_raddr_q;
  assign ram_we        = ram_we_q;
  assign ram_waddr     = ram_waddr_q;
  assign ram_wdata     = ram_wdata_q;

endmodule

// File: tb/tb_inst_ram_arbiter.sv
// tb/tb_inst_ram_arbiter.sv - self-checking bench for inst_ram_arbiter
// Directed vector table, hand sequences, and randomized traffic against a transaction-level model.
module tb_inst_ram_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          clr, f_req, w_req, ram_rfin, ram_wfin;
  logic [AW-1:0] f_addr, w_addr;
  logic [31:0]   w_data, ram_rdata;
  logic [1:0]    prog_sel;
  logic [31:0]   f_data, ram_wdata;
  logic          f_valid, w_ack, prog_switched, ram_re, ram_we, err;
  logic [1:0]    prog_type;
  logic [AW-1:0] ram_raddr, ram_waddr;

  int n_vec = 0;
  int n_err = 0;

  inst_ram_arbiter dut (
    .clk(clk), .clr(clr),
    .f_req(f_req), .f_addr(f_addr), .f_data(f_data), .f_valid(f_valid),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
    .prog_sel(prog_sel), .prog_type(prog_type), .prog_switched(prog_switched),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_rfin(ram_rfin),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wfin(ram_wfin),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic clr; logic fr; logic [9:0] fa; logic wr; logic [9:0] wa; logic [31:0] wd;
    logic [1:0] ps; logic rfin; logic wfin; logic [31:0] rdata;
    logic ere; logic [9:0] era; logic ewe; logic [9:0] ewa; logic [31:0] ewd;
    logic efv; logic [31:0] efd; logic ewk; logic [1:0] ept; logic eps;
  } vec_t;

  vec_t tv [27];

  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  bit ram_auto;
  int ram_lat, rd_cnt, wr_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name, input int bound);
    n_vec++;
    n_err++;
    $display("FAIL %s: no completion within %0d cycles", name, bound);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("inv re_we exclusive", 32'(ram_re & ram_we), 0);
    chk("inv pulses exclusive", 32'(32'(f_valid) + 32'(w_ack) + 32'(prog_switched) > 1), 0);
  endtask

  // Behavioural RAM: completes each access ram_lat+1 cycles after it sees the strobe.
  task automatic ram_step();
    if (!ram_auto) return;
    if (ram_rfin) ram_rfin = 1'b0;
    else if (ram_re) begin
      if (rd_cnt >= ram_lat) begin
        ram_rfin  = 1'b1;
        ram_rdata = ram_mem[ram_raddr[9:2]];
        rd_cnt    = 0;
        ram_lat   = $urandom_range(1, 4);
      end else rd_cnt++;
    end
    if (ram_wfin) ram_wfin = 1'b0;
    else if (ram_we) begin
      if (wr_cnt >= ram_lat) begin
        ram_wfin = 1'b1;
        ram_mem[ram_waddr[9:2]] = ram_wdata;
        wr_cnt   = 0;
        ram_lat  = $urandom_range(1, 4);
      end else wr_cnt++;
    end
  endtask

  task automatic do_reset();
    ram_auto = 1'b0; rd_cnt = 0; wr_cnt = 0; ram_lat = 1;
    clr = 1'b1; f_req = 1'b0; w_req = 1'b0; f_addr = '0; w_addr = '0; w_data = '0;
    prog_sel = '0; ram_rfin = 1'b0; ram_wfin = 1'b0; ram_rdata = '0;
    tick();
    tick();
    clr = 1'b0;
    chk("reset err", 32'(err), 0);
  endtask

  task automatic mem_init();
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = (i * 32'h01010101) ^ 32'h9E3779B9;
      ref_mem[i] = ram_mem[i];
    end
  endtask

  int kinds [3];
  int n_done, cyc, hi, done_kind, prev_kind, f_age, w_age, s_age;
  bit fp, wp, sp, have_prev, prev_oth;
  logic [9:0] fa, wa;
  logic [31:0] wd;
  logic [1:0] cur_sel, nsel;

  initial begin
    //        clr fr fa      wr wa      wd            ps rf wf rdata         | re ra      we wa      wd            fv fd            wk pt ps
    tv[0]  = '{1, 0, 0,      0, 0,      0,            0, 0, 0, 0,            0, 0,      0, 0,      0,            0, 0,            0, 0, 0};
    tv[1]  = '{0, 1, 'h010,  0, 0,      0,            0, 0, 0, 0,            1, 'h010,  0, 0,      0,            0, 0,            0, 0, 0};
    tv[2]  = '{0, 1, 'h010,  0, 0,      0,            0, 0, 0, 0,            1, 'h010,  0, 0,      0,            0, 0,            0, 0, 0};
    tv[3]  = '{0, 1, 'h010,  0, 0,      0,            0, 1, 0, 'h12345678,   0, 'h010,  0, 0,      0,            1, 'h12345678,   0, 0, 0};
    tv[4]  = '{0, 1, 'h020,  0, 0,      0,            0, 1, 0, 0,            0, 'h010,  0, 0,      0,            0, 'h12345678,   0, 0, 0};
    tv[5]  = '{0, 1, 'h020,  0, 0,      0,            0, 1, 0, 0,            0, 'h010,  0, 0,      0,            0, 'h12345678,   0, 0, 0};
    tv[6]  = '{0, 1, 'h020,  0, 0,      0,            0, 0, 0, 0,            1, 'h020,  0, 0,      0,            0, 'h12345678,   0, 0, 0};
    tv[7]  = '{0, 1, 'h020,  0, 0,      0,            2, 0, 0, 0,            1, 'h020,  0, 0,      0,            0, 'h12345678,   0, 0, 0};
    tv[8]  = '{0, 1, 'h020,  0, 0,      0,            2, 1, 0, 'hCAFEF00D,   0, 'h020,  0, 0,      0,            1, 'hCAFEF00D,   0, 0, 0};
    tv[9]  = '{0, 0, 0,      0, 0,      0,            2, 0, 0, 0,            0, 'h020,  0, 0,      0,            0, 'hCAFEF00D,   0, 2, 0};
    tv[10] = '{0, 0, 0,      0, 0,      0,            2, 0, 0, 0,            0, 'h020,  0, 0,      0,            0, 'hCAFEF00D,   0, 2, 0};
    tv[11] = '{0, 0, 0,      0, 0,      0,            2, 0, 0, 0,            0, 'h020,  0, 0,      0,            0, 'hCAFEF00D,   0, 2, 1};
    tv[12] = '{0, 0, 0,      0, 0,      0,            2, 0, 0, 0,            0, 'h020,  0, 0,      0,            0, 'hCAFEF00D,   0, 2, 0};
    tv[13] = '{0, 0, 0,      1, 'h044,  'hA5A50001,   2, 0, 0, 0,            0, 'h020,  1, 'h044,  'hA5A50001,   0, 'hCAFEF00D,   0, 2, 0};
    tv[14] = '{0, 0, 0,      1, 'h044,  'hA5A50001,   2, 0, 0, 0,            0, 'h020,  1, 'h044,  'hA5A50001,   0, 'hCAFEF00D,   0, 2, 0};
    tv[15] = '{1, 0, 0,      1, 'h044,  'hA5A50001,   2, 0, 0, 0,            0, 0,      0, 0,      0,            0, 0,            0, 0, 0};
    tv[16] = '{0, 0, 0,      1, 'h044,  'hA5A50001,   2, 0, 0, 0,            0, 0,      0, 0,      0,            0, 0,            0, 2, 0};
    tv[17] = '{0, 0, 0,      1, 'h044,  'hA5A50001,   2, 0, 0, 0,            0, 0,      0, 0,      0,            0, 0,            0, 2, 0};
    tv[18] = '{0, 0, 0,      1, 'h044,  'hA5A50001,   2, 0, 0, 0,            0, 0,      0, 0,      0,            0, 0,            0, 2, 1};
    tv[19] = '{0, 0, 0,      1, 'h044,  'hA5A50001,   2, 0, 0, 0,            0, 0,      1, 'h044,  'hA5A50001,   0, 0,            0, 2, 0};
    tv[20] = '{0, 0, 0,      1, 'h044,  'hA5A50001,   2, 0, 1, 0,            0, 0,      0, 'h044,  'hA5A50001,   0, 0,            1, 2, 0};
    tv[21] = '{0, 0, 0,      0, 0,      0,            2, 0, 0, 0,            0, 0,      0, 'h044,  'hA5A50001,   0, 0,            0, 2, 0};
    tv[22] = '{0, 1, 'h030,  1, 'h048,  'h11112222,   2, 0, 0, 0,            1, 'h030,  0, 'h044,  'hA5A50001,   0, 0,            0, 2, 0};
    tv[23] = '{0, 1, 'h030,  1, 'h048,  'h11112222,   2, 1, 0, 'h0BADBEEF,   0, 'h030,  0, 'h044,  'hA5A50001,   1, 'h0BADBEEF,   0, 2, 0};
    tv[24] = '{0, 0, 0,      1, 'h048,  'h11112222,   2, 0, 0, 0,            0, 'h030,  1, 'h048,  'h11112222,   0, 'h0BADBEEF,   0, 2, 0};
    tv[25] = '{0, 0, 0,      1, 'h048,  'h11112222,   2, 0, 1, 0,            0, 'h030,  0, 'h048,  'h11112222,   0, 'h0BADBEEF,   1, 2, 0};
    tv[26] = '{0, 0, 0,      0, 0,      0,            2, 0, 0, 0,            0, 'h030,  0, 'h048,  'h11112222,   0, 'h0BADBEEF,   0, 2, 0};

    do_reset();
    @(negedge clk);
    for (int i = 0; i < 27; i++) begin
      clr = tv[i].clr; f_req = tv[i].fr; f_addr = tv[i].fa; w_req = tv[i].wr; w_addr = tv[i].wa;
      w_data = tv[i].wd; prog_sel = tv[i].ps; ram_rfin = tv[i].rfin; ram_wfin = tv[i].wfin;
      ram_rdata = tv[i].rdata;
      tick();
      chk($sformatf("row%0d ram_re", i), 32'(ram_re), 32'(tv[i].ere));
      chk($sformatf("row%0d ram_raddr", i), 32'(ram_raddr), 32'(tv[i].era));
      chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(tv[i].ewe));
      chk($sformatf("row%0d ram_waddr", i), 32'(ram_waddr), 32'(tv[i].ewa));
      chk($sformatf("row%0d ram_wdata", i), ram_wdata, tv[i].ewd);
      chk($sformatf("row%0d f_valid", i), 32'(f_valid), 32'(tv[i].efv));
      chk($sformatf("row%0d f_data", i), f_data, tv[i].efd);
      chk($sformatf("row%0d w_ack", i), 32'(w_ack), 32'(tv[i].ewk));
      chk($sformatf("row%0d prog_type", i), 32'(prog_type), 32'(tv[i].ept));
      chk($sformatf("row%0d prog_switched", i), 32'(prog_switched), 32'(tv[i].eps));
    end

    // Both requesters held from reset: completions must alternate starting with the write.
    mem_init();
    do_reset();
    ram_auto = 1'b1;
    f_req = 1'b1; f_addr = 10'h100; w_req = 1'b1; w_addr = 10'h104; w_data = 32'h5555AAAA;
    n_done = 0; cyc = 0;
    while (n_done < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (w_ack && n_done < 3) begin kinds[n_done] = 1; n_done++; w_data = w_data + 1; end
      if (f_valid && n_done < 3) begin kinds[n_done] = 0; n_done++; end
      ram_step();
    end
    if (n_done < 3) fail_bound("both-held order", 100);
    else begin
      chk("both-held first is write", 32'(kinds[0]), 1);
      chk("both-held second is fetch", 32'(kinds[1]), 0);
      chk("both-held third is write", 32'(kinds[2]), 1);
    end

`ifdef INST_ARB_TIMEOUT_EN
    do_reset();
    f_req = 1'b1; f_addr = 10'h0F0;
    tick();
    chk("to grant ram_re", 32'(ram_re), 1);
    ram_rfin = 1'b1; ram_rdata = 32'hDEADBEEF;
    tick();
    chk("to pre-fetch f_data", f_data, 32'hDEADBEEF);
    ram_rfin = 1'b0; f_addr = 10'h0F4;
    tick();
    hi = ram_re ? 1 : 0;
    while (ram_re && hi < 40) begin
      tick();
      if (ram_re) hi++;
    end
    chk("to ram_re high cycles", 32'(hi), 15);
    chk("to f_valid", 32'(f_valid), 1);
    chk("to f_data", f_data, 0);
    chk("to err set", 32'(err), 1);
    f_req = 1'b0;
    tick(); tick(); tick();
    chk("to err sticky", 32'(err), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("to err cleared", 32'(err), 0);
`endif

    // Randomized traffic against the transaction-level model.
    mem_init();
    do_reset();
    ram_auto = 1'b1;
    fp = 0; wp = 0; sp = 0; cur_sel = '0; have_prev = 0; prev_oth = 0; prev_kind = 0;
    f_age = 0; w_age = 0; s_age = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      done_kind = -1;
      if (f_valid) begin
        chk("rnd fetch had request", 32'(fp), 1);
        chk("rnd f_data", f_data, ref_mem[fa[9:2]]);
        done_kind = 0; fp = 0; f_req = 1'b0;
      end
      if (w_ack) begin
        chk("rnd write had request", 32'(wp), 1);
        ref_mem[wa[9:2]] = wd;
        done_kind = 1; wp = 0; w_req = 1'b0;
      end
      if (done_kind >= 0 && have_prev && prev_oth)
        chk("rnd alternation", 32'(done_kind), 32'(1 - prev_kind));
      if (prog_switched) begin
        chk("rnd prog_type", 32'(prog_type), 32'(cur_sel));
        sp = 0;
      end
      f_age = fp ? f_age + 1 : 0;
      w_age = wp ? w_age + 1 : 0;
      s_age = sp ? s_age + 1 : 0;
      if (f_age > 100) begin fail_bound("rnd fetch stall", 100); fp = 0; f_req = 1'b0; f_age = 0; end
      if (w_age > 100) begin fail_bound("rnd write stall", 100); wp = 0; w_req = 1'b0; w_age = 0; end
      if (s_age > 100) begin fail_bound("rnd switch stall", 100); sp = 0; s_age = 0; end
      ram_step();
      if (c < 2700) begin
        if (!fp && $urandom_range(0, 3) == 0) begin
          fa = 10'($urandom_range(0, 15) * 4);
          fp = 1; f_req = 1'b1; f_addr = fa;
        end
        if (!wp && $urandom_range(0, 3) == 0) begin
          wa = 10'($urandom_range(0, 15) * 4); wd = $urandom;
          wp = 1; w_req = 1'b1; w_addr = wa; w_data = wd;
        end
        if (!sp && $urandom_range(0, 30) == 0) begin
          nsel = 2'($urandom_range(0, 3));
          if (nsel != cur_sel) begin cur_sel = nsel; prog_sel = nsel; sp = 1; end
        end
      end
      if (done_kind >= 0) begin
        prev_kind = done_kind;
        prev_oth  = (done_kind == 0) ? wp : fp;
        have_prev = 1;
      end
    end
    chk("rnd drained", 32'({fp, wp, sp}), 0);
    chk("rnd final prog_type", 32'(prog_type), 32'(cur_sel));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_ram_arbiter.md
INST_RAM_ARBITER -- requirements
Module: inst_ram_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W, default 10, instruction RAM byte-address width.
REQ-003 Parameter PT_W, default 2, program-type width.
REQ-004 Parameter TO_CYC, default 15, timeout cycle limit (used only with INST_ARB_TIMEOUT_EN).
REQ-005 Port clk  in  1  system clock, rising edge.
REQ-006 Port clr  in  1  synchronous active-high reset.
REQ-007 Ports f_req in 1, f_addr in ADDR_W  fetch request and byte address, held until f_valid.
REQ-008 Ports f_data out 32, f_valid out 1  fetched word and its one-cycle valid pulse.
REQ-009 Ports w_req in 1, w_addr in ADDR_W, w_data in 32  loader write request, held until w_ack.
REQ-010 Port w_ack  out  1  one-cycle write-complete pulse.
REQ-011 Ports prog_sel in PT_W, prog_type out PT_W, prog_switched out 1  requested program, registered program to RAM, one-cycle switch-done pulse.
REQ-012 Ports ram_re out 1, ram_raddr out ADDR_W, ram_rdata in 32, ram_rfin in 1  RAM read port.
REQ-013 Ports ram_we out 1, ram_waddr out ADDR_W, ram_wdata out 32, ram_wfin in 1  RAM write port.
REQ-014 Port err  out  1  sticky timeout flag.

Function
REQ-015 FSM states SHALL be IDLE, RD, WR, SW; all outputs registered.
REQ-016 IDLE SHALL grant only when ram_rfin=0 and ram_wfin=0 on the same edge.
REQ-017 Priority in IDLE: prog_sel!=prog_type -> SW; else arbitration between w_req and f_req.
REQ-018 Both w_req and f_req high: write wins unless last grant was write (last_w=1), then fetch wins; single requester always wins.
REQ-019 Fetch grant: on edge, ram_re<=1, ram_raddr<=f_addr, last_w<=0, state<=RD.
REQ-020 RD: on edge with ram_rfin=1, f_data<=ram_rdata, f_valid<=1 for one cycle, ram_re<=0, state<=IDLE; minimum fetch latency 2 cycles grant-to-f_valid.
REQ-021 Write grant: ram_we<=1, ram_waddr<=w_addr, ram_wdata<=w_data, last_w<=1, state<=WR.
REQ-022 WR: on edge with ram_wfin=1, ram_we<=0, w_ack<=1 for one cycle, state<=IDLE.
REQ-023 SW: prog_type<=prog_sel on entry; state held 2 cycles; on exit prog_switched<=1 for one cycle, state<=IDLE.
REQ-024 prog_sel changes during RD/WR SHALL not affect prog_type until the transaction ends.
REQ-025 ram_re and ram_we SHALL never be high simultaneously.
REQ-026 f_valid, w_ack, prog_switched SHALL be mutually exclusive per cycle.

Reset
REQ-027 clr=1 SHALL force state IDLE, last_w=0, prog_type=0, f_data=0, and every 1-bit output (f_valid, w_ack, prog_switched, ram_re, ram_we, err) =0, addresses/wdata=0.
REQ-028 clr during RD/WR SHALL drop ram_re/ram_we on that edge, with no f_valid/w_ack issued.

Configuration
REQ-029 Macro INST_ARB_TIMEOUT_EN defined: counter in RD/WR; after TO_CYC cycles without fin, drop ram_re/ram_we, set err=1 (sticky until clr), pulse f_valid with f_data=0 (RD) or w_ack (WR), return to IDLE.
REQ-030 Macro INST_ARB_TIMEOUT_EN undefined: RD/WR wait indefinitely, err tied 0, no counter logic.

Verification
REQ-031 Fetch f_addr=0x010, RAM returns 0x12345678 with rfin one cycle after re -> f_valid one cycle, f_data=0x12345678, ram_re low after.
REQ-032 f_req and w_req high together from reset, both held -> order write, fetch, write; w_ack and f_valid never in same cycle.
REQ-033 prog_sel 0->2 during RD -> read completes first, then prog_type=2, prog_switched pulse 2 cycles after SW entry.
REQ-034 clr asserted in WR -> next cycle ram_we=0, w_ack=0, state IDLE, prog_type=0.
REQ-035 With INST_ARB_TIMEOUT_EN, TO_CYC=15, rfin held 0 -> ram_re drops after 15 RD cycles, err=1, f_data=0; err stays 1 until clr.
REQ-036 rfin held high after f_valid with f_req high -> no new grant until rfin sampled 0.
